// File: rtl/neuron_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neuron_acc_pkg
// Description : Shared word-size definitions and accumulator state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package neuron_acc_pkg;

    localparam int WORD_DATA_WIDTH = 32;
    typedef logic [WORD_DATA_WIDTH-1:0] word_data_bus_t;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        BIAS   = 2'd2,
        OUTPUT = 2'd3
    } acc_state_e;

endpackage
`default_nettype wire

// File: rtl/neuron_acc_if.sv
`default_nettype none
// ============================================================================
// Module      : neuron_acc_if
// Description : Control, product stream and result handshake of one neuron.
// Revision    : 1.0 - initial release
// ============================================================================
interface neuron_acc_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) ();
    logic                  start;
    logic [CNT_WIDTH-1:0]  num_in;
    logic [DATA_WIDTH-1:0] bias;
    logic                  mu_rdy;
    logic [DATA_WIDTH-1:0] mu_out;
    logic                  acc_ack;
    logic [DATA_WIDTH-1:0] acc_out;
    logic                  acc_rdy;
    logic                  busy;
    logic                  drop_err;

    modport master (
        output start, num_in, bias, mu_rdy, mu_out, acc_ack,
        input  acc_out, acc_rdy, busy, drop_err
    );

    modport slave (
        input  start, num_in, bias, mu_rdy, mu_out, acc_ack,
        output acc_out, acc_rdy, busy, drop_err
    );
endinterface
`default_nettype wire

// File: rtl/neuron_acc_sat_clip.sv
`default_nettype none
// ============================================================================
// Module      : sat_clip
// Description : Combinational signed saturator from IN_WIDTH to OUT_WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_clip #(
    parameter int IN_WIDTH  = 41,
    parameter int OUT_WIDTH = 32
) (
    input  wire logic signed [IN_WIDTH-1:0]  i_din,
    output logic signed      [OUT_WIDTH-1:0] o_dout
);
    localparam logic signed [OUT_WIDTH-1:0] C_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] C_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // The value fits only when every bit above the output sign bit copies it.
    logic [IN_WIDTH-OUT_WIDTH:0] w_upper;
    logic                        w_fits;

    always_comb begin
        w_upper = i_din[IN_WIDTH-1:OUT_WIDTH-1];
        w_fits  = (&w_upper) | ~(|w_upper);
        if (w_fits) begin
            o_dout = i_din[OUT_WIDTH-1:0];
        end else if (i_din[IN_WIDTH-1]) begin
            o_dout = C_MIN;
        end else begin
            o_dout = C_MAX;
        end
    end
endmodule
`default_nettype wire

// File: rtl/neuron_acc.sv
`default_nettype none
// ============================================================================
// Module      : neuron_acc
// Description : Sums a counted stream of signed products, adds bias, saturates
//               and holds the result under a valid/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_acc
    import neuron_acc_pkg::*;
#(
    parameter int DATA_WIDTH = WORD_DATA_WIDTH,
    parameter int CNT_WIDTH  = 8,
    parameter int ACC_WIDTH  = DATA_WIDTH + CNT_WIDTH + 1
) (
    input wire logic    clk,
    input wire logic    reset,
    neuron_acc_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    acc_state_e                   r_state;
    acc_state_e                   w_state_next;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic [CNT_WIDTH-1:0]         r_cnt;
    logic [CNT_WIDTH-1:0]         r_num;
    logic [DATA_WIDTH-1:0]        r_bias;
    logic [DATA_WIDTH-1:0]        r_acc_out;
    logic                         r_acc_rdy;
    logic                         r_busy;
    logic                         r_drop_err;

    logic                         w_accept_start;
    logic                         w_accept_prod;
    logic                         w_last_prod;
    logic signed [ACC_WIDTH-1:0]  w_prod_ext;
    logic signed [ACC_WIDTH-1:0]  w_biased;
    logic signed [DATA_WIDTH-1:0] w_sat;

    always_comb begin
        w_accept_start = (r_state == IDLE) && bus.start;
        w_accept_prod  = (r_state == ACCUM) && bus.mu_rdy;
        w_last_prod    = (r_cnt == (r_num - C_CNT_ONE));
        w_prod_ext     = {{(ACC_WIDTH-DATA_WIDTH){bus.mu_out[DATA_WIDTH-1]}}, bus.mu_out};
        w_biased       = r_acc + {{(ACC_WIDTH-DATA_WIDTH){r_bias[DATA_WIDTH-1]}}, r_bias};
    end

    sat_clip #(
        .IN_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH (DATA_WIDTH)
    ) u_sat (
        .i_din  (w_biased),
        .o_dout (w_sat)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_next = (bus.num_in != '0) ? ACCUM : BIAS;
                end
            end
            ACCUM: begin
                if (bus.mu_rdy && w_last_prod) begin
                    w_state_next = BIAS;
                end
            end
            BIAS: begin
                w_state_next = OUTPUT;
            end
            OUTPUT: begin
                if (bus.acc_ack) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_num      <= '0;
            r_bias     <= '0;
            r_acc_out  <= '0;
            r_acc_rdy  <= DISABLE;
            r_busy     <= DISABLE;
            r_drop_err <= DISABLE;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != IDLE);

            if (w_accept_start) begin
                r_num  <= bus.num_in;
                r_bias <= bus.bias;
                r_acc  <= '0;
                r_cnt  <= '0;
            end else if (w_accept_prod) begin
                r_acc <= r_acc + w_prod_ext;
                r_cnt <= r_cnt + C_CNT_ONE;
            end

            if (r_state == BIAS) begin
                r_acc_out <= w_sat;
                r_acc_rdy <= ENABLE;
            end else if ((r_state == OUTPUT) && bus.acc_ack) begin
                r_acc_rdy <= DISABLE;
            end

            // A start accepted on the same edge as a stray product clears the flag.
            if (w_accept_start) begin
                r_drop_err <= DISABLE;
            end else if (bus.mu_rdy && (r_state != ACCUM)) begin
                r_drop_err <= ENABLE;
            end
        end
    end

    assign bus.acc_out  = r_acc_out;
    assign bus.acc_rdy  = r_acc_rdy;
    assign bus.busy     = r_busy;
    assign bus.drop_err = r_drop_err;
endmodule
`default_nettype wire
